// File: rtl/membram_arb_pkg.sv
// Shared types for the membram two-port arbiter: fairness states, grant
// encoding and the streak-counter sizing helper.
package membram_arb_pkg;

   typedef enum logic {
      PRIO_A  = 1'b0,
      FORCE_B = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_A    = 2'd1,
      GNT_B    = 2'd2
   } arb_gnt_e;

   // Bits needed to hold 0..limit inclusive.
   function automatic int streak_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/membram_arb.sv
// Priority arbiter sharing one synchronous-read 8-bit BRAM between the CPU
// (port A) and a secondary master (port B) with bounded starvation for B.
module membram_arb
   import membram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [7:0]            a_wdata,
   output logic                  a_ready,
   output logic                  a_rvalid,
   output logic [7:0]            a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [7:0]            b_wdata,
   output logic                  b_ready,
   output logic                  b_rvalid,
   output logic [7:0]            b_rdata,
   output logic                  mem_sel,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_din,
   input  logic [7:0]            mem_dout
);

   localparam int SW = streak_width(STARVE_LIMIT);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   arb_state_e    r_state;
   arb_state_e    w_state_nxt;
   logic [SW-1:0] r_streak;
   logic [SW-1:0] w_streak_nxt;
   logic [SW-1:0] w_streak_inc;
   arb_gnt_e      w_gnt;
   logic          r_a_rvalid;
   logic          r_b_rvalid;

   // Grant decision: held off entirely while reset is asserted.
   always_comb begin
      w_gnt = GNT_NONE;
      if (rst) begin
         w_gnt = GNT_NONE;
      end else begin
         case (r_state)
            PRIO_A: begin
               if (a_req)      w_gnt = GNT_A;
               else if (b_req) w_gnt = GNT_B;
               else            w_gnt = GNT_NONE;
            end
            FORCE_B: begin
               if (b_req)      w_gnt = GNT_B;
               else if (a_req) w_gnt = GNT_A;
               else            w_gnt = GNT_NONE;
            end
            default: w_gnt = GNT_NONE;
         endcase
      end
   end

   // BRAM request mux; idle cycles leave port A's address/data on the bus.
   always_comb begin
      a_ready  = (w_gnt == GNT_A);
      b_ready  = (w_gnt == GNT_B);
      mem_sel  = (w_gnt != GNT_NONE);
      mem_we   = 1'b0;
      mem_addr = a_addr;
      mem_din  = a_wdata;
      if (w_gnt == GNT_B) begin
         mem_we   = b_we;
         mem_addr = b_addr;
         mem_din  = b_wdata;
      end else if (w_gnt == GNT_A) begin
         mem_we   = a_we;
      end else begin
         mem_we   = 1'b0;
      end
   end

   // Fairness FSM: count A wins while B waits and force B once the limit is hit.
   always_comb begin
      w_state_nxt  = r_state;
      w_streak_nxt = r_streak;
      w_streak_inc = (r_streak >= LIMIT) ? LIMIT : (r_streak + SW'(1));
      if ((w_gnt == GNT_B) || !b_req) begin
         w_state_nxt  = PRIO_A;
         w_streak_nxt = '0;
      end else if (w_gnt == GNT_A) begin
         if ((r_state == PRIO_A) && (w_streak_inc == LIMIT)) begin
            w_state_nxt  = FORCE_B;
            w_streak_nxt = '0;
         end else begin
            w_streak_nxt = w_streak_inc;
         end
      end else begin
         w_state_nxt  = r_state;
         w_streak_nxt = r_streak;
      end
   end

   // State, streak and one-cycle read-valid pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= PRIO_A;
         r_streak   <= '0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_streak   <= w_streak_nxt;
         r_a_rvalid <= (w_gnt == GNT_A) && !a_we;
         r_b_rvalid <= (w_gnt == GNT_B) && !b_we;
      end
   end

   assign a_rvalid = r_a_rvalid;
   assign b_rvalid = r_b_rvalid;
   assign a_rdata  = mem_dout;
   assign b_rdata  = mem_dout;

endmodule
